// File: rtl/serial_frame_tx_if.sv
// Bundle of the word-in / serial-out signals of the frame transmitter.
// The master side drives the start strobe and word; the slave side is the transmitter.
interface serial_frame_tx_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             x_out;
   logic             busy;
   logic             done;

   modport master (
      output start,
      output data_in,
      input  x_out,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data_in,
      output x_out,
      output busy,
      output done
   );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, data LSB first, optional parity, stop bit.
// Every output is a flop; next-cycle output values are derived from next-state values
// so the serial bit appears exactly one cycle after the state decision.
module serial_frame_tx #(
   parameter int WIDTH      = 8,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit ODD_PARITY = 1'b0
) (
   input logic              clock,
   input logic              reset,
   serial_frame_tx_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             x_q, x_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             lastBit;

   assign lastBit = (cnt_q == CW'(WIDTH - 1));

   // State and datapath registers; reset clears everything, including the outputs, at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
         x_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         x_q     <= x_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state plus shift/count/parity updates; a new word is only taken in IDLE or STOP.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      case (state_q)
         IDLE, STOP: begin
            if (bus.start) begin
               state_d = START;
               shift_d = bus.data_in;
               cnt_d   = '0;
               par_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            state_d = DATA;
         end
         DATA: begin
            shift_d = shift_q >> 1;
            par_d   = par_q ^ shift_q[0];
            cnt_d   = cnt_q + CW'(1);
            if (lastBit) begin
               state_d = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            state_d = STOP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, taken from the state and data being entered.
   always_comb begin
      x_d    = 1'b0;
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP);
      case (state_d)
         START:   x_d = 1'b1;
         DATA:    x_d = shift_d[0];
         PARITY:  x_d = par_d ^ ODD_PARITY;
         default: x_d = 1'b0;
      endcase
   end

   assign bus.x_out = x_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: three instances (even parity, odd parity,
// no parity) checked against a queue-based frame model plus fixed vectors.
module tb_serial_frame_tx;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic       startV[3];
   logic [7:0] dataV[3];
   logic       xV[3];
   logic       busyV[3];
   logic       doneV[3];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         dutSel;
      logic [7:0] data;
      int         len;
      logic [15:0] expX;
   } vec_t;

   vec_t vecs[7];

   bit expQ[3][$];
   bit modelAccept;
   bit expX, expBusy, expDone;
   int doneCount, busyCount;

   serial_frame_tx_if #(.WIDTH(8)) ifA ();
   serial_frame_tx_if #(.WIDTH(8)) ifB ();
   serial_frame_tx_if #(.WIDTH(8)) ifC ();

   serial_frame_tx #(.WIDTH(8), .PARITY_EN(1'b1), .ODD_PARITY(1'b0)) dutA (
      .clock(clock), .reset(reset), .bus(ifA));
   serial_frame_tx #(.WIDTH(8), .PARITY_EN(1'b1), .ODD_PARITY(1'b1)) dutB (
      .clock(clock), .reset(reset), .bus(ifB));
   serial_frame_tx #(.WIDTH(8), .PARITY_EN(1'b0), .ODD_PARITY(1'b0)) dutC (
      .clock(clock), .reset(reset), .bus(ifC));

   assign ifA.start   = startV[0];
   assign ifB.start   = startV[1];
   assign ifC.start   = startV[2];
   assign ifA.data_in = dataV[0];
   assign ifB.data_in = dataV[1];
   assign ifC.data_in = dataV[2];
   assign xV[0]    = ifA.x_out;
   assign xV[1]    = ifB.x_out;
   assign xV[2]    = ifC.x_out;
   assign busyV[0] = ifA.busy;
   assign busyV[1] = ifB.busy;
   assign busyV[2] = ifC.busy;
   assign doneV[0] = ifA.done;
   assign doneV[1] = ifB.done;
   assign doneV[2] = ifC.done;

   // 10 ns clock period.
   always #5 clock = ~clock;

   function automatic bit peOf(int d);
      return d != 2;
   endfunction

   function automatic bit oddOf(int d);
      return d == 1;
   endfunction

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0b expected=%0b at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: each instance owns a queue of the x_out bits still to appear;
   // a word is accepted when the line is idle or the ending cycle is the stop bit.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < 3; d++) expQ[d].delete();
      end else begin
         for (int d = 0; d < 3; d++) begin
            modelAccept = (startV[d] === 1'b1) && (expQ[d].size() <= 1);
            if (expQ[d].size() > 0) void'(expQ[d].pop_front());
            if (modelAccept) begin
               expQ[d].push_back(1'b1);
               for (int i = 0; i < 8; i++) expQ[d].push_back(dataV[d][i]);
               if (peOf(d)) expQ[d].push_back((^dataV[d]) ^ oddOf(d));
               expQ[d].push_back(1'b0);
            end
         end
      end
   end

   // Every falling edge, compare all three instances with the model.
   always @(negedge clock) begin
      for (int d = 0; d < 3; d++) begin
         expBusy = (expQ[d].size() > 0);
         expDone = (expQ[d].size() == 1);
         expX    = expBusy ? expQ[d][0] : 1'b0;
         checkOutput($sformatf("model%0d.x", d), xV[d], expX);
         checkOutput($sformatf("model%0d.busy", d), busyV[d], expBusy);
         checkOutput($sformatf("model%0d.done", d), doneV[d], expDone);
      end
   end

   // Strobe one vector's word into its instance and compare the whole frame bit by bit.
   task automatic applyStimulus(input int idx);
      int d;
      int n;
      d = vecs[idx].dutSel;
      n = vecs[idx].len;
      @(negedge clock);
      startV[d] = 1'b1;
      dataV[d]  = vecs[idx].data;
      @(negedge clock);
      startV[d] = 1'b0;
      dataV[d]  = 8'($urandom);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("vec%0d.x[%0d]", idx, i), xV[d], vecs[idx].expX[n-1-i]);
         checkOutput($sformatf("vec%0d.busy[%0d]", idx, i), busyV[d], 1'b1);
         checkOutput($sformatf("vec%0d.done[%0d]", idx, i), doneV[d], (i == n - 1));
         @(negedge clock);
      end
      checkOutput($sformatf("vec%0d.idleBusy", idx), busyV[d], 1'b0);
      checkOutput($sformatf("vec%0d.idleX", idx), xV[d], 1'b0);
   endtask

   // Main sequence: reset/idle, vector table, hand-written corner cases, random traffic.
   initial begin
      vecs[0] = '{0, 8'hA5, 11, 16'b11010010100};
      vecs[1] = '{1, 8'h07, 11, 16'b11110000000};
      vecs[2] = '{2, 8'hFF, 10, 16'b1111111110};
      vecs[3] = '{0, 8'h01, 11, 16'b11000000010};
      vecs[4] = '{1, 8'h00, 11, 16'b10000000010};
      vecs[5] = '{2, 8'h80, 10, 16'b1000000010};
      vecs[6] = '{0, 8'h3C, 11, 16'b10011110000};

      for (int d = 0; d < 3; d++) begin
         startV[d] = 1'b0;
         dataV[d]  = 8'h00;
      end

      repeat (3) @(negedge clock);
      reset = 1'b1;

      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("idle%0d.x", d), xV[d], 1'b0);
            checkOutput($sformatf("idle%0d.busy", d), busyV[d], 1'b0);
            checkOutput($sformatf("idle%0d.done", d), doneV[d], 1'b0);
         end
      end

      for (int v = 0; v < 7; v++) applyStimulus(v);

      // Second strobe during DATA must be dropped.
      @(negedge clock);
      startV[0] = 1'b1;
      dataV[0]  = 8'h3C;
      @(negedge clock);
      startV[0] = 1'b0;
      repeat (3) @(negedge clock);
      startV[0] = 1'b1;
      dataV[0]  = 8'hFF;
      @(negedge clock);
      startV[0] = 1'b0;
      repeat (8) @(negedge clock);
      for (int k = 0; k < 5; k++) begin
         checkOutput("ignored.busy", busyV[0], 1'b0);
         checkOutput("ignored.x", xV[0], 1'b0);
         @(negedge clock);
      end

      // Reset during the 4th data bit of 8'h5A (bit3 = 1).
      @(negedge clock);
      startV[0] = 1'b1;
      dataV[0]  = 8'h5A;
      @(negedge clock);
      startV[0] = 1'b0;
      repeat (4) @(negedge clock);
      checkOutput("midRst.xBefore", xV[0], 1'b1);
      checkOutput("midRst.busyBefore", busyV[0], 1'b1);
      #2 reset = 1'b0;
      #1;
      checkOutput("midRst.x", xV[0], 1'b0);
      checkOutput("midRst.busy", busyV[0], 1'b0);
      checkOutput("midRst.done", doneV[0], 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(3);

      // start held high: back-to-back 10-cycle frames on the no-parity instance.
      doneCount = 0;
      busyCount = 0;
      @(negedge clock);
      startV[2] = 1'b1;
      dataV[2]  = 8'hFF;
      for (int k = 0; k < 35; k++) begin
         @(negedge clock);
         if (k == 24) startV[2] = 1'b0;
         if (doneV[2] === 1'b1) doneCount++;
         if (busyV[2] === 1'b1) busyCount++;
      end
      checks++;
      if (doneCount != 3) begin
         failures++;
         $display("[TB] FAIL b2b.doneCount actual=%0d expected=3", doneCount);
      end
      checks++;
      if (busyCount != 30) begin
         failures++;
         $display("[TB] FAIL b2b.busyCount actual=%0d expected=30", busyCount);
      end

      // Random traffic on all instances, with one asynchronous reset pulse in the middle.
      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         for (int d = 0; d < 3; d++) begin
            startV[d] = ($urandom_range(0, 3) == 0);
            dataV[d]  = 8'($urandom);
         end
         if (k == 200) begin
            #2 reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
         end
      end
      for (int d = 0; d < 3; d++) startV[d] = 1'b0;
      repeat (15) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmitter end of the single-bit serial stream (x_in style) consumed by the team's sequence-detector FSMs.
- Accepts a parallel word on a start strobe and frames it as a serial bit stream: start bit, data bits LSB first, optional parity bit, stop bit.
- Sits in front of a detector/receiver FSM and drives its serial input, one bit per clock.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 1..16).
- PARITY_EN, 1, 1 = append parity bit after data; 0 = no parity bit.
- ODD_PARITY, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to send data_in; sampled only in IDLE or STOP.
- data_in  input  WIDTH  word to transmit; captured on the edge that accepts start.
- x_out  output  1  serial bit stream; idle level 0.
- busy  output  1  high while a frame is on x_out (START..STOP inclusive).
- done  output  1  one-cycle pulse during the STOP bit of each frame.

Behaviour:
- Single clock; reset asynchronous, active-low (reset==0 forces reset state immediately, independent of clock).
- Reset values: state=IDLE, x_out=0, busy=0, done=0, shift register=0, bit counter=0, parity accumulator=0.
- All outputs are registered (Moore); no combinational path from start/data_in to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: x_out=0, busy=0. If start=1 at rising edge: capture data_in into shift register, clear bit counter and parity accumulator, go to START. Else stay.
- START: x_out=1 for exactly one cycle, busy=1. Next: DATA.
- DATA: x_out = shift register bit 0; each cycle shift right by 1, XOR transmitted bit into parity accumulator, increment counter. After WIDTH cycles go to PARITY if PARITY_EN=1, else STOP.
- PARITY: one cycle; x_out = accumulator XOR ODD_PARITY (even: total ones in data+parity is even). Next: STOP.
- STOP: x_out=0 for one cycle, busy=1, done=1. If start=1 at the end of STOP: capture data_in, go directly to START (back-to-back frames, no idle gap). Else go to IDLE.
- Frame length on x_out = 2 + WIDTH + PARITY_EN cycles.
- Latency: start accepted at edge N gives start bit on x_out in cycle N+1 and first data bit in cycle N+2.
- start is ignored in START, DATA and PARITY. No queuing: a strobe in those states is dropped.
- data_in changes after capture have no effect on the frame in flight.
- Counter width is ceil(log2(WIDTH+1)). Counter wrap must not occur within a frame.
- Reset asserted mid-frame: frame aborted immediately. x_out, busy and done go to 0 asynchronously. After reset release the block waits in IDLE for a new start.
- start held continuously high: frames repeat back-to-back, each capturing data_in at its STOP (or the initial IDLE) edge.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> x_out=0, busy=0, done=0 throughout.
- WIDTH=8, PARITY_EN=1, even parity, data_in=8'hA5, one-cycle start -> x_out sequence 1,1,0,1,0,0,1,0,1,0,0 (11 cycles); busy high for those 11 cycles; done high only on the last one.
- Same frame with ODD_PARITY=1 and data_in=8'h07 -> x_out 1,1,1,1,0,0,0,0,0,0,0; parity bit 0 (three ones, already odd).
- PARITY_EN=0, data_in=8'hFF, start held high for 25 cycles -> back-to-back 10-cycle frames 1,1,1,1,1,1,1,1,1,0 with no idle gap; done pulses every 10 cycles.
- start pulsed again during DATA of a frame carrying 8'h3C -> strobe ignored; frame completes unchanged; block returns to IDLE with no second frame.
- reset driven low during the 4th data bit -> x_out=0, busy=0 immediately (before the next clock edge); after release, a start with 8'h01 produces a clean full frame.
